// File: rtl/x_23k640_pkg.sv
// -----------------------------------------------------------------------------
// x_23k640_pkg
// Shared types and default widths for the 23K640 SPI serial-clock generator.
//   state_t     : burst FSM states. LEAD and LAG are only reachable when the
//                 generator is built with X_23K640_SCK_LEAD_EN defined.
//   spi_mode_t  : SPI mode bits latched at burst start.
//   PERIOD_W_DEF: default width of the half-period setting.
//   NBITS_W_DEF : default width of the burst-length setting.
// -----------------------------------------------------------------------------
package x_23k640_pkg;

  localparam int unsigned PERIOD_W_DEF = 8;
  localparam int unsigned NBITS_W_DEF  = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LEAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_LAG  = 2'd3
  } state_t;

  typedef struct packed {
    logic cpol;  // SCK idle level
    logic cpha;  // 0: capture on leading edge, 1: capture on trailing edge
  } spi_mode_t;

  // Odd edges (1, 3, 5, ...) are leading edges. Before an edge is taken, the
  // edge counter holds the number of edges already produced, so the next edge
  // is leading exactly when that count is even.
  function automatic logic next_edge_is_leading(input logic done_count_lsb);
    return ~done_count_lsb;
  endfunction

endpackage : x_23k640_pkg

// File: rtl/x_23k640_sck_div.sv
// -----------------------------------------------------------------------------
// x_23k640_sck_div
// Half-period counter for the SCK generator. While enabled it counts
// 0..period and then wraps, flagging the final count with 'top'. While
// disabled it is held at zero, so every enable starts a full half-period.
//   i_clk  in  1         system clock
//   i_rst  in  1         asynchronous, active-high reset
//   en     in  1         count enable (generator is outside IDLE)
//   period in  PERIOD_W  half-period minus one
//   top    out 1         high in the last cycle of each half-period
// -----------------------------------------------------------------------------
module x_23k640_sck_div #(
  parameter int unsigned PERIOD_W = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  output logic                top
);

  localparam logic [PERIOD_W-1:0] CNT_ONE = PERIOD_W'(1);

  logic [PERIOD_W-1:0] cnt;

  assign top = en && (cnt == period);

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // values from before the edge, independent of process evaluation order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (!en || top) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

endmodule : x_23k640_sck_div

// File: rtl/x_23k640_sck_gen.sv
// -----------------------------------------------------------------------------
// x_23k640_sck_gen
// Gated SPI serial-clock generator for the 23K640 SRAM controller. One
// accepted request produces a burst of exactly nbits SCK cycles in the SPI
// mode given by cpol/cpha, together with launch (shift) and capture (sample)
// strobes for the shift register. Strobes are asserted in the cycle before
// the SCK edge they belong to.
//
// Build option:
//   X_23K640_SCK_LEAD_EN  adds one idle half-period (LEAD) after acceptance
//                         and one (LAG) after the last edge, both busy and
//                         edge-free, to give chip-select setup/hold. o_done
//                         then pulses at the end of LAG.
//
// Ports:
//   i_clk     in  1         system clock
//   i_rst     in  1         asynchronous, active-high reset
//   i_period  in  PERIOD_W  half-period minus one (latched on accepted start)
//   i_cpol    in  1         SCK idle level (latched on start, drives idle SCK)
//   i_cpha    in  1         0: sample leading edge, 1: sample trailing edge
//   i_nbits   in  NBITS_W   SCK cycles per burst (latched on accepted start)
//   i_start   in  1         burst request, accepted only when idle
//   i_stop    in  1         synchronous abort, wins over i_start
//   o_busy    out 1         burst in progress
//   o_shift   out 1         launch strobe, SCK toggles next cycle
//   o_sample  out 1         capture strobe, SCK toggles next cycle
//   o_done    out 1         one-cycle pulse on normal burst completion
//   o_sck     out 1         registered SPI clock
// -----------------------------------------------------------------------------
module x_23k640_sck_gen
  import x_23k640_pkg::*;
#(
  parameter int unsigned PERIOD_W = PERIOD_W_DEF,
  parameter int unsigned NBITS_W  = NBITS_W_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [PERIOD_W-1:0] i_period,
  input  logic                i_cpol,
  input  logic                i_cpha,
  input  logic [NBITS_W-1:0]  i_nbits,
  input  logic                i_start,
  input  logic                i_stop,
  output logic                o_busy,
  output logic                o_shift,
  output logic                o_sample,
  output logic                o_done,
  output logic                o_sck
);

  // Where a burst enters after acceptance and where it goes after its final
  // SCK edge. With the guard phases enabled these are the LEAD/LAG states.
`ifdef X_23K640_SCK_LEAD_EN
  localparam state_t START_STATE = ST_LEAD;
  localparam state_t END_STATE   = ST_LAG;
`else
  localparam state_t START_STATE = ST_RUN;
  localparam state_t END_STATE   = ST_IDLE;
`endif

  localparam logic [NBITS_W:0] EDGE_ONE = (NBITS_W + 1)'(1);

  state_t               state;
  state_t               state_nxt;

  // Burst settings captured at acceptance; mid-burst input changes are ignored.
  logic [PERIOD_W-1:0]  period_q;
  logic [NBITS_W-1:0]   nbits_q;
  spi_mode_t            mode_q;

  // Number of SCK half-edges already produced in this burst (0..2*nbits).
  logic [NBITS_W:0]     edge_cnt;
  logic [NBITS_W:0]     edge_inc;

  logic                 sck_q;
  logic                 done_q;

  logic                 div_en;
  logic                 top;
  logic                 accept;
  logic                 last_edge;
  logic                 leading;
  logic                 edge_now;
  logic                 burst_end;

  // ---------------------------------------------------------------------------
  // Half-period divider
  // ---------------------------------------------------------------------------
  assign div_en = (state != ST_IDLE);

  x_23k640_sck_div #(
    .PERIOD_W (PERIOD_W)
  ) u_div (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .en     (div_en),
    .period (period_q),
    .top    (top)
  );

  // ---------------------------------------------------------------------------
  // Shared decode
  // ---------------------------------------------------------------------------
  assign accept    = (state == ST_IDLE) && i_start && !i_stop;
  assign edge_inc  = edge_cnt + EDGE_ONE;
  // The edge about to be produced is edge_inc; the burst has 2*nbits edges.
  assign last_edge = (edge_inc == {nbits_q, 1'b0});
  assign leading   = next_edge_is_leading(edge_cnt[0]);
  assign edge_now  = (state == ST_RUN) && top;

  // A burst completes when the final edge is taken (no lag phase) or when the
  // lag half-period expires. An abort in the same cycle suppresses it.
  assign burst_end = top && !i_stop &&
                     (((state == ST_RUN) && last_edge && (END_STATE == ST_IDLE)) ||
                      (state == ST_LAG));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  // NOTE: every variable assigned in a combinational block gets a default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (accept && (|i_nbits)) state_nxt = START_STATE;
      ST_LEAD: if (top)                  state_nxt = ST_RUN;
      ST_RUN:  if (top && last_edge)     state_nxt = END_STATE;
      ST_LAG:  if (top)                  state_nxt = ST_IDLE;
      default:                           state_nxt = ST_IDLE;
    endcase
    if (i_stop) begin
      state_nxt = ST_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (registers only, so strobes are glitch-free of input timing)
  // ---------------------------------------------------------------------------
  always_comb begin
    o_busy   = (state != ST_IDLE);
    o_shift  = 1'b0;
    o_sample = 1'b0;
    if (edge_now) begin
      if (!mode_q.cpha) begin
        // Bit 0 is preloaded, so capture leads and launch trails; the final
        // trailing edge has no next bit to launch.
        o_sample = leading;
        o_shift  = !leading && !last_edge;
      end else begin
        o_shift  = leading;
        o_sample = !leading;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Burst settings
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      period_q <= '0;
      nbits_q  <= '0;
      mode_q   <= '0;
    end else if (accept) begin
      period_q <= i_period;
      nbits_q  <= i_nbits;
      mode_q   <= '{cpol: i_cpol, cpha: i_cpha};
    end
  end

  // ---------------------------------------------------------------------------
  // Edge counter, SCK flop and done pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      edge_cnt <= '0;
      sck_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // Zero-length requests complete immediately without leaving IDLE.
      done_q <= (accept && !(|i_nbits)) || burst_end;

      if ((state == ST_IDLE) || i_stop) begin
        edge_cnt <= '0;
      end else if (edge_now) begin
        edge_cnt <= edge_inc;
      end

      // Idle SCK tracks the live polarity input; an abort parks it at the
      // burst's own idle level. A full burst returns there by construction.
      if (state == ST_IDLE) begin
        sck_q <= i_cpol;
      end else if (i_stop) begin
        sck_q <= mode_q.cpol;
      end else if (edge_now) begin
        sck_q <= ~sck_q;
      end
    end
  end

  assign o_sck  = sck_q;
  assign o_done = done_q;

endmodule : x_23k640_sck_gen
